// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the single-port data RAM: burst-limited round-robin,
// one transfer per cycle, 1-cycle read responses and out-of-range error pulses.
module ram_port_arbiter #(
  parameter int unsigned RAM_DEPTH = 411700,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_write,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_write,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        ram_en,
  output logic        ram_write,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        owner
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [31:0] DEPTH = 32'(RAM_DEPTH);

  logic [1:0]  req;
  logic [1:0]  wr;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  ready;
  logic [1:0]  rvalid;
  logic [1:0]  err;
  logic [31:0] rdata [2];

  logic          owner_reg, owner_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          resp_sel_reg, resp_sel_next;
  logic          resp_rd_reg, resp_rd_next;
  logic          resp_err_reg, resp_err_next;

  logic        other;
  logic        grant_valid;
  logic        grant_sel;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_write;
  logic        in_range;

  assign req      = {m1_req, m0_req};
  assign wr       = {m1_write, m0_write};
  assign addr[0]  = m0_addr;
  assign addr[1]  = m1_addr;
  assign wdata[0] = m0_wdata;
  assign wdata[1] = m1_wdata;
  assign other    = ~owner_reg;

  // Owner keeps the port until its burst is used up, but only if the other
  // master actually wants it; reset forces no grant so nothing reaches the RAM.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = owner_reg;
    if (nreset) begin
      if (req[owner_reg] && ((cnt_reg < MAX_CNT) || !req[other])) begin
        grant_valid = 1'b1;
      end else if (req[other]) begin
        grant_valid = 1'b1;
        grant_sel   = other;
      end
    end
  end

  assign sel_addr  = addr[grant_sel];
  assign sel_wdata = wdata[grant_sel];
  assign sel_write = wr[grant_sel];
  assign in_range  = (sel_addr < DEPTH);

  assign ram_en    = grant_valid & in_range;
  assign ram_write = ram_en & sel_write;
  assign ram_addr  = ram_en ? sel_addr : 32'h0;
  assign ram_wdata = ram_en ? sel_wdata : 32'h0;

  always_comb begin
    owner_next    = owner_reg;
    cnt_next      = cnt_reg;
    resp_sel_next = grant_sel;
    resp_rd_next  = grant_valid & ~sel_write;
    resp_err_next = grant_valid & ~in_range;
    if (!grant_valid) begin
      cnt_next = '0;
    end else if (grant_sel == owner_reg) begin
      cnt_next = (cnt_reg == MAX_CNT) ? MAX_CNT : cnt_reg + CW'(1);
    end else begin
      owner_next = grant_sel;
      cnt_next   = CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      owner_reg    <= 1'b0;
      cnt_reg      <= '0;
      resp_sel_reg <= 1'b0;
      resp_rd_reg  <= 1'b0;
      resp_err_reg <= 1'b0;
    end else begin
      owner_reg    <= owner_next;
      cnt_reg      <= cnt_next;
      resp_sel_reg <= resp_sel_next;
      resp_rd_reg  <= resp_rd_next;
      resp_err_reg <= resp_err_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign ready[gi]  = grant_valid & (grant_sel == 1'(gi));
      assign rvalid[gi] = nreset & resp_rd_reg & (resp_sel_reg == 1'(gi));
      assign err[gi]    = nreset & resp_err_reg & (resp_sel_reg == 1'(gi));
      // Error responses never forward whatever the RAM left on its read bus.
      assign rdata[gi]  = (rvalid[gi] & ~resp_err_reg) ? ram_rdata : 32'h0;
    end
  endgenerate

  assign m0_ready  = ready[0];
  assign m1_ready  = ready[1];
  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_err    = err[0];
  assign m1_err    = err[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];
  assign owner     = nreset & owner_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: behavioural RAM, per-scenario tasks,
// and a response scoreboard checked every cycle on the falling edge.
module tb_ram_port_arbiter;

  logic        clock, nreset;
  logic        m0_req, m0_write, m0_ready, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_write, m1_ready, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        ram_en, ram_write, owner;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  typedef struct {
    int          m;
    bit          rd;
    bit          er;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  ram_port_arbiter dut (
    .clock(clock), .nreset(nreset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  initial ram_rdata = 32'h0;
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_write) mem[ram_addr] = ram_wdata;
      else ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
    end
  end

  // Response scoreboard: one entry per expected rvalid/err cycle.
  always @(negedge clock) begin
    logic [1:0]  rv, er;
    logic [31:0] rd [2];
    exp_t        e;
    bit          have;
    bit          x_rv, x_er;
    logic [31:0] x_rd;
    rv = {m1_rvalid, m0_rvalid};
    er = {m1_err, m0_err};
    rd[0] = m0_rdata;
    rd[1] = m1_rdata;
    have = 1'b0;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL stale_resp m%0d cyc=%0d expected at cyc=%0d was never consumed", e.m, cyc_cnt, e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
      e = exp_q.pop_front();
      have = 1'b1;
    end
    for (int m = 0; m < 2; m++) begin
      x_rv = have && e.m == m && e.rd;
      x_er = have && e.m == m && e.er;
      x_rd = (have && e.m == m) ? e.data : 32'h0;
      total++;
      if (rv[m] !== x_rv || er[m] !== x_er || rd[m] !== x_rd) begin
        bad++;
        $display("FAIL resp_m%0d cyc=%0d got rvalid=%b err=%b rdata=%h want rvalid=%b err=%b rdata=%h",
                 m, cyc_cnt, rv[m], er[m], rd[m], x_rv, x_er, x_rd);
      end
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    mem[a] = d;
    shadow[a] = d;
  endtask

  function automatic logic [31:0] rd_shadow(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 32'h0;
  endfunction

  task automatic push_exp(input int m, input bit rd, input bit er, input logic [31:0] d);
    exp_t e;
    e.m = m; e.rd = rd; e.er = er; e.data = d; e.cyc = cyc_cnt + 1;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    idle();
    nreset = 0;
    next();
    nreset = 1;
  endtask

  task automatic test_reset();
    preload(32'd5, 32'h5555_5555);
    nreset = 0;
    m0_req = 1; m0_write = 1; m0_addr = 32'd5; m0_wdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if ({ram_en, ram_write, m0_ready, m1_ready, owner} !== 5'b0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got en/wr/rdy0/rdy1/owner=%b want 00000", i,
                 {ram_en, ram_write, m0_ready, m1_ready, owner});
      end
      next();
    end
    total++;
    if (mem[32'd5] !== 32'h5555_5555) begin
      bad++;
      $display("FAIL reset_ram5 got %h want 55555555", mem[32'd5]);
    end
    idle();
    nreset = 1;
    $display("test_reset: done");
  endtask

  task automatic test_single();
    m0_req = 1; m0_write = 1; m0_addr = 32'd100; m0_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    total++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || ram_en !== 1'b1 || ram_write !== 1'b1 ||
        ram_addr !== 32'd100 || ram_wdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL single_write got rdy=%b%b en=%b wr=%b addr=%0d wdata=%h want rdy=10 en=1 wr=1 addr=100 wdata=deadbeef",
               m0_ready, m1_ready, ram_en, ram_write, ram_addr, ram_wdata);
    end
    shadow[32'd100] = 32'hDEAD_BEEF;
    next();
    m0_write = 0;
    @(negedge clock);
    total++;
    if (m0_ready !== 1'b1 || ram_en !== 1'b1 || ram_write !== 1'b0 || ram_addr !== 32'd100) begin
      bad++;
      $display("FAIL single_read got rdy=%b en=%b wr=%b addr=%0d want 1 1 0 100",
               m0_ready, ram_en, ram_write, ram_addr);
    end
    push_exp(0, 1, 0, rd_shadow(32'd100));
    next();
    idle();
    @(negedge clock);
    total++;
    if (ram_en !== 1'b0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
      bad++;
      $display("FAIL single_idle got en=%b addr=%h wdata=%h want 0 0 0", ram_en, ram_addr, ram_wdata);
    end
    next();
    $display("test_single: done");
  endtask

  task automatic test_contention();
    logic [31:0] a [2];
    int em, eo;
    for (int i = 0; i < 16; i++) begin
      preload(32'd200 + 32'(i), 32'hA000_0000 + 32'(i));
      preload(32'd300 + 32'(i), 32'hB000_0000 + 32'(i));
    end
    apply_reset();
    a[0] = 32'd200;
    a[1] = 32'd300;
    m0_req = 1; m1_req = 1;
    for (int c = 0; c < 16; c++) begin
      m0_addr = a[0];
      m1_addr = a[1];
      @(negedge clock);
      em = (c / 4) % 2;
      eo = (c == 0) ? 0 : ((c - 1) / 4) % 2;
      total++;
      if ({m1_ready, m0_ready} !== ((em == 1) ? 2'b10 : 2'b01) || ram_addr !== a[em]) begin
        bad++;
        $display("FAIL contention_grant cycle=%0d got rdy1/rdy0=%b%b addr=%0d want m%0d addr=%0d",
                 c, m1_ready, m0_ready, ram_addr, em, a[em]);
      end
      total++;
      if (owner !== 1'(eo)) begin
        bad++;
        $display("FAIL contention_owner cycle=%0d got %b want %0d", c, owner, eo);
      end
      push_exp(em, 1, 0, rd_shadow(a[em]));
      a[em] = a[em] + 1;
      next();
    end
    idle();
    @(negedge clock);
    next();
    $display("test_contention: done");
  endtask

  task automatic test_lone();
    for (int i = 0; i < 10; i++) preload(32'd400 + 32'(i), 32'hC000_0000 + 32'(i));
    apply_reset();
    m1_req = 1;
    for (int c = 0; c < 10; c++) begin
      m1_addr = 32'd400 + 32'(c);
      @(negedge clock);
      total++;
      if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || owner !== ((c == 0) ? 1'b0 : 1'b1)) begin
        bad++;
        $display("FAIL lone_m1 cycle=%0d got rdy1=%b rdy0=%b owner=%b want 1 0 %0d",
                 c, m1_ready, m0_ready, owner, (c == 0) ? 0 : 1);
      end
      push_exp(1, 1, 0, rd_shadow(m1_addr));
      next();
    end
    m1_addr = 32'd410;
    m0_req = 1; m0_addr = 32'd100;
    @(negedge clock);
    total++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      bad++;
      $display("FAIL lone_takeover got rdy0=%b rdy1=%b want 1 0", m0_ready, m1_ready);
    end
    push_exp(0, 1, 0, rd_shadow(32'd100));
    next();
    m0_req = 0;
    @(negedge clock);
    total++;
    if (m1_ready !== 1'b1) begin
      bad++;
      $display("FAIL lone_resume got rdy1=%b want 1", m1_ready);
    end
    push_exp(1, 1, 0, rd_shadow(32'd410));
    next();
    idle();
    @(negedge clock);
    next();
    $display("test_lone: done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      m0_req = 1; m0_write = 0; m0_addr = 32'd200 + 32'(i);
      @(negedge clock);
      total++;
      if (m0_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_read%0d got rdy0=%b want 1", i, m0_ready);
      end
      push_exp(0, 1, 0, rd_shadow(m0_addr));
      next();
    end
    m0_write = 1; m0_addr = 32'd500; m0_wdata = 32'h1357_9BDF;
    @(negedge clock);
    shadow[32'd500] = 32'h1357_9BDF;
    next();
    m0_write = 0;
    @(negedge clock);
    total++;
    if (m0_ready !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 32'd500) begin
      bad++;
      $display("FAIL b2b_readback got rdy0=%b en=%b addr=%0d want 1 1 500", m0_ready, ram_en, ram_addr);
    end
    push_exp(0, 1, 0, rd_shadow(32'd500));
    next();
    idle();
    @(negedge clock);
    next();
    $display("test_back_to_back: done");
  endtask

  task automatic test_oor();
    preload(32'd411699, 32'h0BAD_F00D);
    m1_req = 1; m1_write = 0; m1_addr = 32'd411700;
    @(negedge clock);
    total++;
    if (m1_ready !== 1'b1 || ram_en !== 1'b0 || ram_write !== 1'b0) begin
      bad++;
      $display("FAIL oor_read_accept got rdy1=%b en=%b wr=%b want 1 0 0", m1_ready, ram_en, ram_write);
    end
    push_exp(1, 1, 1, 32'h0);
    next();
    m1_write = 1; m1_addr = 32'hFFFF_FFFF; m1_wdata = 32'h1234_5678;
    @(negedge clock);
    total++;
    if (m1_ready !== 1'b1 || ram_en !== 1'b0 || ram_write !== 1'b0) begin
      bad++;
      $display("FAIL oor_write_accept got rdy1=%b en=%b wr=%b want 1 0 0", m1_ready, ram_en, ram_write);
    end
    push_exp(1, 0, 1, 32'h0);
    next();
    m1_write = 0; m1_addr = 32'd411699;
    @(negedge clock);
    total++;
    if (m1_ready !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 32'd411699) begin
      bad++;
      $display("FAIL oor_last_word got rdy1=%b en=%b addr=%0d want 1 1 411699", m1_ready, ram_en, ram_addr);
    end
    push_exp(1, 1, 0, rd_shadow(32'd411699));
    next();
    idle();
    @(negedge clock);
    next();
    $display("test_oor: done");
  endtask

  task automatic test_reset_mid();
    for (int i = 4; i < 10; i++) preload(32'(i), 32'hD000_0000 + 32'(i));
    m0_req = 1; m0_write = 0;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 32'd4 + 32'(i);
      @(negedge clock);
      total++;
      if (m0_ready !== 1'b1) begin
        bad++;
        $display("FAIL midrst_burst%0d got rdy0=%b want 1", i, m0_ready);
      end
      if (i < 3) push_exp(0, 1, 0, rd_shadow(m0_addr));
      next();
    end
    nreset = 0;
    idle();
    @(negedge clock);
    next();
    nreset = 1;
    m0_req = 1; m0_addr = 32'd8;
    m1_req = 1; m1_addr = 32'd9;
    @(negedge clock);
    total++;
    if (owner !== 1'b0 || m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_first got owner=%b rdy0=%b rdy1=%b want 0 1 0", owner, m0_ready, m1_ready);
    end
    push_exp(0, 1, 0, rd_shadow(32'd8));
    next();
    idle();
    @(negedge clock);
    next();
    $display("test_reset_mid: done");
  endtask

  initial begin
    idle();
    nreset = 0;
    test_reset();
    test_single();
    test_contention();
    test_lone();
    test_back_to_back();
    test_oor();
    test_reset_mid();
    next();
    next();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
